// File: rtl/bram_seq_pkg.sv
// bram_seq_pkg: shared types and default widths for the block-RAM test sequencer
package bram_seq_pkg;
  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH = 128;
  typedef enum logic [1:0] {SCAN = 2'd0, FILL = 2'd1, CHECK = 2'd2} mode_t;
  typedef enum logic [2:0] {ST_IDLE, ST_FILL, ST_READ, ST_DRAIN, ST_DONE} state_t;
endpackage

// File: rtl/bram_seq_ctrl.sv
// bram_seq_ctrl: walks a block RAM once to fill it, checksum it, or check it against a pattern
module bram_seq_ctrl
  import bram_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] pattern,
  input  logic              inc,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              err_flag,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout
);
  state_t state, state_n;
  logic [ADDR_W-1:0] addr, addr_n, proc_addr;
  logic [DATA_W-1:0] pat_q, pat_n, wr_word, chk_word;
  logic inc_q, inc_n, check_q, load, last, proc;

  assign load = state == ST_IDLE && start;
  assign pat_n = load ? pattern : pat_q;
  assign inc_n = load ? inc : inc_q;
  assign last = addr == ADDR_W'(DEPTH - 1);
  assign proc_addr = addr - 1'b1;
  assign proc = (state == ST_READ && addr != '0) || state == ST_DRAIN;
  assign wr_word = pat_n + (inc_n ? DATA_W'(addr_n) : '0);
  assign chk_word = pat_q + (inc_q ? DATA_W'(proc_addr) : '0);
  assign busy = state == ST_FILL || state == ST_READ || state == ST_DRAIN;
  assign done = state == ST_DONE;
  assign err_flag = err_cnt != '0;

  // next state and address counter; the counter wraps to 0 after the last word
  always_comb begin
    state_n = state;
    addr_n = addr;
    unique case (state)
      ST_IDLE: if (start) begin
        state_n = mode == FILL ? ST_FILL : ST_READ;
        addr_n = '0;
      end
      ST_FILL: begin
        addr_n = addr + 1'b1;
        state_n = last ? ST_DONE : ST_FILL;
      end
      ST_READ: begin
        addr_n = addr + 1'b1;
        state_n = last ? ST_DRAIN : ST_READ;
      end
      ST_DRAIN: state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // state, latched operation settings and result accumulators
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      addr <= '0;
      pat_q <= '0;
      inc_q <= 1'b0;
      check_q <= 1'b0;
      checksum <= '0;
      err_cnt <= '0;
      first_err_addr <= '0;
    end else begin
      state <= state_n;
      addr <= addr_n;
      if (load) begin
        pat_q <= pattern;
        inc_q <= inc;
        check_q <= mode == CHECK;
        checksum <= '0;
        err_cnt <= '0;
        first_err_addr <= '0;
      end else if (proc) begin
        checksum <= checksum + mem_dout;
        if (check_q && mem_dout != chk_word) begin
          err_cnt <= err_cnt + 1'b1;
          if (err_cnt == '0) first_err_addr <= proc_addr;
        end
      end
    end
  end

  // registered memory port driven from the next state so writes never leak outside FILL
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we <= 1'b0;
      mem_raddr <= '0;
      mem_waddr <= '0;
      mem_din <= '0;
    end else begin
      mem_we <= state_n == ST_FILL;
      if (state_n == ST_FILL) begin
        mem_waddr <= addr_n;
        mem_din <= wr_word;
      end
      if (state_n == ST_READ) mem_raddr <= addr_n;
    end
  end
endmodule
